bus_initiator: RTL and testbench
================================

// Module: bus_initiator
// PURPOSE
//  Bus master for the 6502-style system bus. Turns a command/stream interface into single-byte
//  read/write cycles on A/DO/R_W_n and captures returned data from DI. Sits beside the CPU and
//  drives the same decoded address space (ROM E000-FFFF, UART C000-DFFF, RAM 0000-1FFF).
//  Used for debug loading, memory dump and block fill; bus arbitration against the CPU is external.
// PARAMETERS
//  READ_LATENCY  2   CLK edges from A stable to DI valid (sync ROM/RAM read + registered mux)
//  ADDR_W        16  bus address width
// PORTS
//  CLK        in   1       system clock, all logic on posedge
//  RESET      in   1       synchronous, active-high reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       high only in IDLE; command accepted on cmd_valid & cmd_ready
//  cmd_write  in   1       1 = write burst, 0 = read burst
//  cmd_addr   in   ADDR_W  start address
//  cmd_len    in   8       byte count; 0 encodes 256
//  wr_valid   in   1       write byte offered
//  wr_ready   out  1       write byte accepted on wr_valid & wr_ready
//  wr_data    in   8       write byte
//  rd_valid   out  1       read byte available
//  rd_ready   in   1       consumer takes read byte on rd_valid & rd_ready
//  rd_data    out  8       read byte, stable while rd_valid
//  busy       out  1       high in every state except IDLE
//  A          out  ADDR_W  bus address (registered)
//  DO         out  8       bus write data toward responders (registered)
//  DI         in   8       bus read data from responders
//  R_W_n      out  1       1 = read, 0 = write; low exactly one CLK per written byte
// BEHAVIOUR
//  Reset: state IDLE, A=0000, DO=00, R_W_n=1, rd_valid=0, rd_data=00, wr_ready=0, busy=0,
//   counters cleared. Reset mid-burst aborts immediately; no further strobe, pending byte dropped.
//  States: IDLE, W_WAIT, W_STROBE, R_ADDR, R_WAIT, R_HOLD.
//  IDLE: cmd_ready=1. Accept -> latch addr, len (0->256 held in 9-bit count), dir;
//   go W_WAIT if write else R_ADDR. cmd_valid outside IDLE is ignored (not queued).
//  W_WAIT: wr_ready=1, R_W_n=1. On wr handshake: A<=addr, DO<=wr_data, R_W_n<=0 -> W_STROBE.
//  W_STROBE: one cycle, A/DO/R_W_n=0 stable whole cycle. Next edge: R_W_n<=1, addr+1, count-1;
//   count reaches 0 -> IDLE else W_WAIT. Min 2 CLK per written byte.
//  R_ADDR: A<=addr, R_W_n=1, latency counter<=READ_LATENCY -> R_WAIT.
//  R_WAIT: counter decrements each CLK, A held; when counter==1 at posedge, rd_data<=DI,
//   rd_valid<=1 -> R_HOLD. DI sampled exactly READ_LATENCY+1 edges after A was registered.
//  R_HOLD: rd_valid=1, rd_data stable until rd_ready. On handshake rd_valid<=0, addr+1, count-1;
//   count 0 -> IDLE else R_ADDR. Back-to-back reads with rd_ready=1: READ_LATENCY+2 CLK/byte.
//  Address arithmetic modulo 2^ADDR_W: FFFF+1 -> 0000, burst continues across wrap.
//  Last-byte handshake and return to IDLE: cmd_ready asserts the cycle after leaving the final state.
//  A and DO hold last driven value in IDLE; R_W_n is never low outside W_STROBE.
//  Bus responder value for unmapped space (A5) is returned as ordinary data, no error flag.
// STRUCTURE
//  Shared package bus_pkg: state enum, ADDR_W, region base/mask constants (ROM/RAM/UART),
//   unmapped read value 8'hA5 for bench checks.
//  Single module; no sub-module needed (latency counter and burst counter are inline).
// TESTING
//  Bench instantiates system IO block as responder on A/DO/DI/R_W_n.
//  1 Write burst addr=0010 len=3 data 11,22,33 -> three R_W_n low pulses of 1 CLK at 0010..0012;
//    read burst addr=0010 len=3 returns 11,22,33 in order.
//  2 Read addr=E000 len=1 -> rd_data equals ROM word 0, rd_valid exactly READ_LATENCY+2 CLK after accept.
//  3 Read addr=2000 len=2 (unmapped) -> rd_data A5,A5; busy drops after second handshake.
//  4 Write addr=FFFF len=2 data AA,BB -> strobes at FFFF then 0000 (wrap); RAM[0000]=BB.
//  5 len=0 write of incrementing bytes at 0100 -> exactly 256 strobes, last at 01FF, then IDLE.
//  6 RESET asserted in W_STROBE of byte 2 and with rd_ready=0 in R_HOLD -> next CLK R_W_n=1,
//    rd_valid=0, IDLE; no strobe after reset; cmd_valid during busy never accepted.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the system-bus initiator: FSM states, bus geometry,
// and the decoded address map the initiator drives.
package bus_initiator_pkg;

    localparam int BUS_ADDR_W       = 16;
    localparam int BUS_READ_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_STROBE,
        R_ADDR,
        R_WAIT,
        R_HOLD
    } state_t;

    // Address map: each region is an 8 KiB window selected by A[15:13].
    localparam logic [15:0] REGION_MASK = 16'hE000;
    localparam logic [15:0] ROM_BASE    = 16'hE000;
    localparam logic [15:0] UART_BASE   = 16'hC000;
    localparam logic [15:0] RAM_BASE    = 16'h0000;

    // Value the responders put on DI for addresses nobody decodes.
    localparam logic [7:0] UNMAPPED_RD = 8'hA5;

    function automatic logic in_region(input logic [15:0] a, input logic [15:0] base);
        return (a & REGION_MASK) == base;
    endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Command/stream side plus 6502-style bus side of the initiator.
// master = the initiator, slave = everything around it (host + responders).
interface bus_initiator_if #(
    parameter int ADDR_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [7:0]        wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [7:0]        rd_data;
    logic              busy;
    logic [ADDR_W-1:0] A;
    logic [7:0]        DO;
    logic [7:0]        DI;
    logic              R_W_n;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, DI,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, A, DO, R_W_n
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, DI,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, A, DO, R_W_n
    );
endinterface

// File: rtl/bus_initiator.sv
// Bus master that turns read/write burst commands into single-byte bus cycles.
// Every output is a register so the bus and the stream side never see glitches.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int READ_LATENCY = BUS_READ_LATENCY,
    parameter int ADDR_W       = BUS_ADDR_W
) (
    input  logic            CLK,
    input  logic            RESET,
    bus_initiator_if.master bus
);

    localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;      // address of the byte currently being handled
    logic [8:0]        count;     // bytes left, 256 needs the ninth bit
    logic [LAT_W-1:0]  lat;       // edges left until DI is valid
    logic [ADDR_W-1:0] a_q;
    logic [7:0]        do_q;
    logic              rw_n_q;
    logic              rd_valid_q;
    logic [7:0]        rd_data_q;
    logic              wr_ready_q;
    logic              cmd_ready_q;
    logic              busy_q;

    assign bus.A         = a_q;
    assign bus.DO        = do_q;
    assign bus.R_W_n     = rw_n_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;

    // Burst sequencer: state, counters and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            addr        <= '0;
            count       <= '0;
            lat         <= '0;
            a_q         <= '0;
            do_q        <= '0;
            rw_n_q      <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            wr_ready_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        addr        <= bus.cmd_addr;
                        count       <= (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.cmd_write) begin
                            state      <= W_WAIT;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state <= R_ADDR;
                        end
                    end
                end
                W_WAIT: begin
                    if (bus.wr_valid && wr_ready_q) begin
                        a_q        <= addr;
                        do_q       <= bus.wr_data;
                        rw_n_q     <= 1'b0;
                        wr_ready_q <= 1'b0;
                        state      <= W_STROBE;
                    end
                end
                W_STROBE: begin
                    // Strobe lasts exactly this one cycle.
                    rw_n_q <= 1'b1;
                    addr   <= addr + ADDR_W'(1);
                    count  <= count - 9'd1;
                    if (count == 9'd1) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        state      <= W_WAIT;
                        wr_ready_q <= 1'b1;
                    end
                end
                R_ADDR: begin
                    a_q   <= addr;
                    lat   <= LAT_W'(READ_LATENCY);
                    state <= R_WAIT;
                end
                R_WAIT: begin
                    lat <= lat - LAT_W'(1);
                    if (lat == LAT_W'(1)) begin
                        rd_data_q  <= bus.DI;
                        rd_valid_q <= 1'b1;
                        state      <= R_HOLD;
                    end
                end
                R_HOLD: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        addr       <= addr + ADDR_W'(1);
                        count      <= count - 9'd1;
                        if (count == 9'd1) begin
                            state       <= IDLE;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            state <= R_ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: a behavioural responder (RAM/ROM/UART/unmapped) on
// the bus, a directed vector table, multi-cycle corner sequences, and random
// bursts checked against a byte-level memory model.
module tb_bus_initiator;
    import bus_initiator_pkg::*;

    localparam int RL = 2;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    bus_initiator_if #(.ADDR_W(16)) bif ();

    bus_initiator #(.READ_LATENCY(RL), .ADDR_W(16)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bif)
    );

    localparam logic [7:0] UART_RD = 8'h3C;

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ---------------- responder: one registered stage from A to DI ----------
    logic [7:0] ram [0:8191];
    logic [7:0] di_q;
    bit         ram_clr = 1'b0;
    assign bif.DI = di_q;

    always @(posedge CLK) begin
        if (!ram_clr) begin
            for (int i = 0; i < 8192; i++) ram[i] <= 8'h00;
            ram_clr <= 1'b1;
        end else if (bif.R_W_n === 1'b0 && in_region(bif.A, RAM_BASE)) begin
            ram[bif.A[12:0]] <= bif.DO;
        end
        if (in_region(bif.A, RAM_BASE))       di_q <= ram[bif.A[12:0]];
        else if (in_region(bif.A, ROM_BASE))  di_q <= rom_byte(bif.A);
        else if (in_region(bif.A, UART_BASE)) di_q <= UART_RD;
        else                                  di_q <= UNMAPPED_RD;
    end

    // ---------------- reference model: what memory should hold -------------
    logic [7:0] mdl_ram [0:8191];

    function automatic logic [7:0] exp_read(input logic [15:0] a);
        if (in_region(a, RAM_BASE))  return mdl_ram[a[12:0]];
        if (in_region(a, ROM_BASE))  return rom_byte(a);
        if (in_region(a, UART_BASE)) return UART_RD;
        return UNMAPPED_RD;
    endfunction

    // ---------------- bus monitor ------------------------------------------
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t act_q[$];
    wr_t exp_q[$];
    bit  mon_en = 1'b0;
    bit  prev_low = 1'b0;
    int  viol_long = 0, viol_rdy = 0, viol_rwbusy = 0;

    // Record every write strobe and watch the always-true bus rules.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (bif.R_W_n === 1'b0) begin
                act_q.push_back({bif.A, bif.DO});
                if (prev_low) viol_long++;
                if (bif.busy !== 1'b1) viol_rwbusy++;
            end
            if (bif.cmd_ready === bif.busy) viol_rdy++;
            prev_low = (bif.R_W_n === 1'b0);
        end
    end

    // ---------------- checking helpers -------------------------------------
    int n_cmp = 0, n_err = 0;
    int chk_idx = 0;
    logic [7:0] wbuf [0:255];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_cmd(input bit wr, input logic [15:0] addr, input int n);
        int t = 0;
        bif.cmd_valid = 1'b1;
        bif.cmd_write = wr;
        bif.cmd_addr  = addr;
        bif.cmd_len   = n[7:0];
        while (bif.cmd_ready !== 1'b1 && t < 300) begin tick(); t++; end
        if (t >= 300) check("cmd_accept_timeout", 64'd0, 64'd1);
        tick();
        bif.cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        int t = 0;
        repeat (gap) tick();
        bif.wr_valid = 1'b1;
        bif.wr_data  = d;
        while (bif.wr_ready !== 1'b1 && t < 100) begin tick(); t++; end
        if (t >= 100) check("wr_ready_timeout", 64'd0, 64'd1);
        tick();
        bif.wr_valid = 1'b0;
    endtask

    task automatic recv(output logic [7:0] d, input int hold);
        int t = 0;
        d = 8'h00;
        bif.rd_ready = 1'b0;
        while (bif.rd_valid !== 1'b1 && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            check("rd_valid_timeout", 64'd0, 64'd1);
        end else begin
            repeat (hold) tick();
            d = bif.rd_data;
            bif.rd_ready = 1'b1;
            tick();
            bif.rd_ready = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bif.busy !== 1'b0 && t < 300) begin tick(); t++; end
        if (t >= 300) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        if (in_region(a, RAM_BASE)) mdl_ram[a[12:0]] = d;
    endtask

    task automatic compare_strobes(input string name);
        check({name, "_strobe_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = chk_idx; i < exp_q.size(); i++)
            if (i < act_q.size()) check({name, "_strobe"}, 64'(act_q[i]), 64'(exp_q[i]));
        chk_idx = exp_q.size();
    endtask

    task automatic run_write(input string name, input logic [15:0] addr, input int n, input int gap_max);
        do_cmd(1'b1, addr, n);
        for (int i = 0; i < n; i++) begin
            expect_write(addr + 16'(i), wbuf[i]);
            send(wbuf[i], $urandom_range(0, gap_max));
        end
        wait_idle();
        compare_strobes(name);
    endtask

    task automatic run_read(input string name, input logic [15:0] addr, input int n, input int hold_max);
        logic [7:0] d;
        do_cmd(1'b0, addr, n);
        for (int i = 0; i < n; i++) begin
            recv(d, $urandom_range(0, hold_max));
            check(name, 64'(d), 64'(exp_read(addr + 16'(i))));
        end
        check({name, "_busy_after_last"}, 64'(bif.busy), 64'd0);
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        int          len;
        logic [23:0] data;   // write bytes, first byte in [23:16]
        logic [23:0] exp;    // expected read bytes, first byte in [23:16]
        string       name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0]  d;
        logic [15:0] a;
        int          lat, base;

        bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0; bif.cmd_len = '0;
        bif.wr_valid  = 1'b0; bif.wr_data   = '0;   bif.rd_ready = 1'b0;
        for (int i = 0; i < 8192; i++) mdl_ram[i] = 8'h00;

        vecs[0] = '{1'b1, 16'h0010, 3, 24'h112233, 24'h0,      "wr_0010"};
        vecs[1] = '{1'b0, 16'h0010, 3, 24'h0,      24'h112233, "rd_0010"};
        vecs[2] = '{1'b0, 16'hE000, 1, 24'h0,      24'hBA0000, "rd_rom_e000"};
        vecs[3] = '{1'b0, 16'h2000, 2, 24'h0,      24'hA5A500, "rd_unmapped"};
        vecs[4] = '{1'b1, 16'hFFFF, 2, 24'hAABB00, 24'h0,      "wr_wrap"};
        vecs[5] = '{1'b0, 16'h0000, 1, 24'h0,      24'hBB0000, "rd_ram0_after_wrap"};

        // Reset state.
        RESET = 1'b1;
        repeat (3) tick();
        check("reset_state",
              {27'd0, bif.A, bif.DO, bif.R_W_n, bif.rd_valid, bif.rd_data, bif.wr_ready, bif.busy, bif.cmd_ready},
              {27'd0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        RESET = 1'b0;
        mon_en = 1'b1;
        tick();

        // Table-driven directed bursts.
        foreach (vecs[v]) begin
            if (vecs[v].wr) begin
                for (int i = 0; i < vecs[v].len; i++) wbuf[i] = vecs[v].data[23 - 8*i -: 8];
                run_write(vecs[v].name, vecs[v].addr, vecs[v].len, 1);
            end else begin
                do_cmd(1'b0, vecs[v].addr, vecs[v].len);
                for (int i = 0; i < vecs[v].len; i++) begin
                    recv(d, i);
                    check(vecs[v].name, 64'(d), 64'(vecs[v].exp[23 - 8*i -: 8]));
                end
                check({vecs[v].name, "_busy_after_last"}, 64'(bif.busy), 64'd0);
            end
        end
        check("wrap_strobe_ffff", 64'(act_q[3].a), 64'h0000_FFFF);
        check("wrap_strobe_0000", 64'(act_q[4].a), 64'h0000_0000);

        // Read latency: counting the accept edge as edge 1, rd_valid rises on
        // edge READ_LATENCY+2, i.e. READ_LATENCY+1 edges after the accept edge.
        do_cmd(1'b0, 16'hE000, 1);
        lat = 0;
        while (bif.rd_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
        check("rd_latency_edges", 64'(lat), 64'(RL + 1));
        recv(d, 0);
        check("rd_latency_data", 64'(d), 64'h0000_00BA);

        // len=0 encodes a 256-byte burst.
        base = act_q.size();
        for (int i = 0; i < 256; i++) wbuf[i] = 8'(i);
        run_write("wr_len256", 16'h0100, 256, 0);
        check("len256_strobes", 64'(act_q.size() - base), 64'd256);
        check("len256_last_addr", 64'(act_q[act_q.size() - 1].a), 64'h0000_01FF);
        run_read("rd_back_len256", 16'h01FE, 2, 0);

        // Reset while strobing byte 2, with a second command waiting the whole time.
        do_cmd(1'b1, 16'h0040, 3);
        bif.cmd_valid = 1'b1; bif.cmd_write = 1'b1; bif.cmd_addr = 16'h1234; bif.cmd_len = 8'd1;
        expect_write(16'h0040, 8'h77);
        send(8'h77, 0);
        expect_write(16'h0041, 8'h88);
        send(8'h88, 0);
        check("in_strobe_before_reset", 64'(bif.R_W_n), 64'd0);
        RESET = 1'b1;
        tick();
        bif.cmd_valid = 1'b0;
        check("reset_mid_write",
              {59'd0, bif.R_W_n, bif.busy, bif.cmd_ready, bif.wr_ready, bif.A == 16'h0000},
              {59'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
        bif.wr_valid = 1'b1; bif.wr_data = 8'h99;
        tick();
        RESET = 1'b0;
        repeat (5) tick();
        bif.wr_valid = 1'b0;
        compare_strobes("reset_write");
        run_read("rd_after_reset", 16'h0040, 3, 0);

        // Reset while a read byte is held and not consumed.
        do_cmd(1'b0, 16'h2000, 2);
        lat = 0;
        while (bif.rd_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
        RESET = 1'b1;
        tick();
        check("reset_in_hold", {61'd0, bif.rd_valid, bif.busy, bif.cmd_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
        RESET = 1'b0;
        repeat (3) tick();
        check("no_rd_after_reset", 64'(bif.rd_valid), 64'd0);

        // Random bursts against the memory model.
        for (int k = 0; k < 30; k++) begin
            int n, r;
            n = $urandom_range(1, 6);
            r = $urandom_range(0, 4);
            case (r)
                0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
                1:       a = 16'($urandom_range(16'hE000, 16'hFFFF));
                2:       a = 16'($urandom_range(16'hC000, 16'hDFFF));
                3:       a = 16'($urandom_range(16'h2000, 16'hBFFF));
                default: a = 16'($urandom_range(16'hFFFC, 16'hFFFF));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                run_write("rand_wr", a, n, 2);
            end else begin
                run_read("rand_rd", a, n, 2);
            end
        end

        tick();
        check("strobe_one_cycle", 64'(viol_long), 64'd0);
        check("cmd_ready_iff_idle", 64'(viol_rdy), 64'd0);
        check("rw_low_only_busy", 64'(viol_rwbusy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
